tenyr_mem_arbiter: RTL and testbench
====================================

// Module: tenyr_mem_arbiter
// PURPOSE
// - Sits directly downstream of the core: merges its instruction-fetch and data (load/store) channels onto one
//   single-port memory bus with req/ack handshake and arbitrary wait states.
// - Returns fetched words and load data to the core with ready pulses, so the core can stall on slow memory.
// - Watchdog raises a sticky bus_err (wired into the core's halt vector) when a slave never acknowledges.
// PARAMETERS
// - ADDR_W   32   address width, both channels and bus
// - DATA_W   32   data width
// - TIMEOUT  255  cycles without m_ack before bus_err; 0 disables the watchdog (8-bit counter, 1..255 legal)
// PORTS
// - clk      in   1       clock; all state updates on negedge clk (matches core)
// - reset_n  in   1       reset, synchronous, active-low
// - i_req    in   1       instruction fetch request (level, held until i_rdy)
// - i_addr   in   ADDR_W  fetch address, stable while i_req
// - i_rdy    out  1       1-cycle pulse: i_data valid
// - i_data   out  DATA_W  fetched word, held until next i_rdy
// - d_req    in   1       data request (level, held until d_rdy)
// - d_we     in   1       1 = store, 0 = load
// - d_addr   in   ADDR_W  data address
// - d_wdata  in   DATA_W  store data
// - d_rdy    out  1       1-cycle pulse: data access complete
// - d_rdata  out  DATA_W  load result, held until next load completes
// - m_req    out  1       bus request
// - m_we     out  1       bus write enable
// - m_addr   out  ADDR_W  bus address
// - m_wdata  out  DATA_W  bus write data
// - m_ack    in   1       slave acknowledge; read data valid in same cycle
// - m_rdata  in   DATA_W  bus read data
// - bus_err  out  1       sticky timeout flag, to HALT vector
// BEHAVIOUR
// - All outputs registered. Reset (reset_n=0 at clock edge): state IDLE, every output 0, counter 0, cache tag invalid.
// - States: IDLE, BUS_I, BUS_D, RESP, ERR.
// - IDLE: if d_req -> latch d_we/d_addr/d_wdata onto m_*, m_req=1, go BUS_D; else if i_req -> m_we=0,
//   m_addr=i_addr, m_req=1, go BUS_I. d_req and i_req together: data wins (older insn); i_req stays pending.
// - BUS_x: m_* held stable until m_ack sampled 1. On ack: m_req=0, m_we=0, x_rdy=1 for one cycle, i_data or
//   d_rdata <= m_rdata (d_rdata untouched on store), go RESP. m_ack outside BUS_x ignored.
// - RESP: rdy pulse cycle; requests not sampled; next state IDLE. Requester must drop or change req by IDLE.
// - Latency: request seen in IDLE at edge N -> m_req high after N; ack sampled at edge M -> rdy high after M;
//   zero-wait slave gives req-to-rdy of 2 edges, back-to-back accesses every 3 edges.
// - Watchdog: counter clears on entry to BUS_x, +1 per BUS_x cycle without ack; reaching TIMEOUT -> ERR:
//   m_req=0, bus_err=1, no rdy. ERR exits only via reset.
// - Reset mid-transaction: m_req drops at the reset edge, outstanding access abandoned, no rdy issued;
//   slaves tolerate abandoned requests.
// - Requests dropped while in BUS_x do not abort the bus access; completion still pulses rdy.
// CONFIGURATION
// - TENYR_ARB_IFETCH_CACHE_EN defined: one-entry fetch cache (tag, valid, word).
//   - Filled on every BUS_I completion.
//   - In IDLE with no d_req, i_req with i_addr == tag && valid -> no bus access, go RESP, i_rdy next cycle.
//   - Any completed store with d_addr == tag clears valid; reset clears valid.
// - Undefined: no cache; every fetch goes to the bus.
// TESTING
// - Reset, then i_req @0x1000, slave 0-wait m_rdata=0xDEADBEEF -> m_req/m_addr=0x1000 one edge later;
//   i_rdy pulse with i_data=0xDEADBEEF two edges after request.
// - d_req store 0x20<-0x12345678 and i_req @0x1001 same cycle -> bus sees write 0x20 first, then read 0x1001;
//   d_rdy precedes i_rdy.
// - Load 0x40, slave 5 wait states, m_rdata=0xCAFEF00D -> m_req/m_addr stable 6 cycles;
//   d_rdy once with d_rdata=0xCAFEF00D.
// - TIMEOUT=4, slave never acks -> bus_err=1 after 4 BUS cycles, m_req=0, no rdy;
//   further requests ignored until reset_n=0 clears all outputs.
// - reset_n low while in BUS_D -> next cycle m_req=0, no d_rdy, late m_ack ignored, fresh i_req served normally.
// - With TENYR_ARB_IFETCH_CACHE_EN: fetch 0x1000 twice -> second one has no m_req;
//   store to 0x1000 then fetch 0x1000 -> bus read occurs.

Source files
------------

// File: rtl/tenyr_mem_arbiter.sv
// ============================================================================
// tenyr_mem_arbiter
// ----------------------------------------------------------------------------
// Merges the core's instruction-fetch channel and its data (load/store)
// channel onto one single-port memory bus. The bus uses a req/ack handshake
// and tolerates any number of wait states.
//
// Completion is signalled back to the core with one-cycle ready pulses, so
// the core can stall on slow memory. A watchdog raises a sticky bus_err when
// a slave never acknowledges. Only reset clears bus_err.
//
// All state updates happen on the falling edge of clk, matching the core.
// Every output is registered.
//
// Parameters:
//   ADDR_W   address width (fetch, data and bus)
//   DATA_W   data width
//   TIMEOUT  bus cycles without m_ack before bus_err; 0 disables the watchdog
//            (8-bit counter, 1..255 legal)
//
// Ports:
//   clk      clock, state updates on negedge
//   reset_n  synchronous active-low reset
//   i_req    fetch request (level), i_addr fetch address
//   i_rdy    1-cycle pulse, i_data holds fetched word until next i_rdy
//   d_req    data request (level), d_we store/load, d_addr, d_wdata
//   d_rdy    1-cycle pulse, d_rdata holds load result until next load
//   m_req    bus request, m_we, m_addr, m_wdata
//   m_ack    slave acknowledge, m_rdata valid in the same cycle
//   bus_err  sticky watchdog timeout flag
//
// Optional feature (macro TENYR_ARB_IFETCH_CACHE_EN):
//   Adds a one-entry fetch cache (tag, valid, word). A fetch that hits is
//   answered without any bus access. A completed store to the cached
//   address invalidates the entry.
// ============================================================================
module tenyr_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        BUS_I,
        BUS_D,
        RESP,
        ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wd_cnt;

`ifdef TENYR_ARB_IFETCH_CACHE_EN
    logic [ADDR_W-1:0] cache_tag;
    logic              cache_valid;
    logic [DATA_W-1:0] cache_word;
`endif

    // Data requests win over fetches. The pending load/store belongs to an
    // older instruction than the fetch, so it must be served first. The
    // fetch request simply stays asserted until it is served.
    //
    // While a bus access is in progress (BUS_I/BUS_D), m_* are not touched
    // until m_ack arrives. The watchdog counts the cycles that pass without
    // an ack. The counter is already cleared when the state is entered.
    always_ff @(negedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wd_cnt      <= 8'd0;
            i_rdy       <= 1'b0;
            i_data      <= '0;
            d_rdy       <= 1'b0;
            d_rdata     <= '0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            bus_err     <= 1'b0;
`ifdef TENYR_ARB_IFETCH_CACHE_EN
            cache_tag   <= '0;
            cache_valid <= 1'b0;
            cache_word  <= '0;
`endif
        end else begin
            i_rdy <= 1'b0;
            d_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        wd_cnt  <= 8'd0;
                        state   <= BUS_D;
                    end
`ifdef TENYR_ARB_IFETCH_CACHE_EN
                    else if (i_req && cache_valid && (i_addr == cache_tag)) begin
                        // Cache hit: skip the bus and answer one edge later.
                        i_data <= cache_word;
                        i_rdy  <= 1'b1;
                        state  <= RESP;
                    end
`endif
                    else if (i_req) begin
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                        wd_cnt <= 8'd0;
                        state  <= BUS_I;
                    end
                end

                BUS_I, BUS_D: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        state <= RESP;
                        if (state == BUS_I) begin
                            i_rdy  <= 1'b1;
                            i_data <= m_rdata;
`ifdef TENYR_ARB_IFETCH_CACHE_EN
                            cache_tag   <= m_addr;
                            cache_word  <= m_rdata;
                            cache_valid <= 1'b1;
`endif
                        end else begin
                            d_rdy <= 1'b1;
                            // On a store, keep the previous load result.
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
`ifdef TENYR_ARB_IFETCH_CACHE_EN
                            if (m_we && (m_addr == cache_tag)) begin
                                cache_valid <= 1'b0;
                            end
`endif
                        end
                    end else if ((TIMEOUT_CNT != 8'd0) && (wd_cnt == TIMEOUT_CNT - 8'd1)) begin
                        // This cycle is the TIMEOUT-th one without an ack.
                        state   <= ERR;
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end

                // The ready pulse is visible during RESP. Requests are not
                // sampled here, which gives the requester one cycle to drop
                // or change its request.
                RESP: begin
                    state <= IDLE;
                end

                ERR: begin
                    state <= ERR;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tenyr_mem_arbiter.sv
// ============================================================================
// tb_tenyr_mem_arbiter
// ----------------------------------------------------------------------------
// Directed testbench for tenyr_mem_arbiter.
//
// Instances:
//   dut  default TIMEOUT, driven by a simple wait-state slave model
//   wdut TIMEOUT=4, its slave never acknowledges
//
// Timing: the DUT updates on negedge clk. The bench drives inputs and
// samples outputs on posedge clk.
// ============================================================================
module tb_tenyr_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rdy;
    logic [31:0] i_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rdy;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata;
    logic        bus_err;

    logic        wd_i_req;
    logic [31:0] wd_i_addr;
    logic        wd_i_rdy;
    logic [31:0] wd_i_data;
    logic        wd_d_req;
    logic        wd_d_we;
    logic [31:0] wd_d_addr;
    logic [31:0] wd_d_wdata;
    logic        wd_d_rdy;
    logic [31:0] wd_d_rdata;
    logic        wd_m_req;
    logic        wd_m_we;
    logic [31:0] wd_m_addr;
    logic [31:0] wd_m_wdata;
    logic        wd_m_ack = 1'b0;
    logic [31:0] wd_m_rdata = 32'h0;
    logic        wd_bus_err;

    // Slave model controls
    int          wait_states = 0;
    int          wcnt = 0;
    logic        slave_en = 1'b1;
    logic        force_ack = 1'b0;
    logic [32:0] bus_log[$];

    int          compared = 0;
    int          mismatched = 0;
    int          n0;

    tenyr_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdy   (i_rdy),
        .i_data  (i_data),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdy   (d_rdy),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .bus_err (bus_err)
    );

    tenyr_mem_arbiter #(.TIMEOUT(4)) wdut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (wd_i_req),
        .i_addr  (wd_i_addr),
        .i_rdy   (wd_i_rdy),
        .i_data  (wd_i_data),
        .d_req   (wd_d_req),
        .d_we    (wd_d_we),
        .d_addr  (wd_d_addr),
        .d_wdata (wd_d_wdata),
        .d_rdy   (wd_d_rdy),
        .d_rdata (wd_d_rdata),
        .m_req   (wd_m_req),
        .m_we    (wd_m_we),
        .m_addr  (wd_m_addr),
        .m_wdata (wd_m_wdata),
        .m_ack   (wd_m_ack),
        .m_rdata (wd_m_rdata),
        .bus_err (wd_bus_err)
    );

    always #5 clk = ~clk;

    // Slave: acks after wait_states idle cycles of a held request.
    always @(posedge clk) begin
        if (force_ack) begin
            m_ack = 1'b1;
        end else if (m_req && slave_en) begin
            if (wcnt == wait_states) begin
                m_ack = 1'b1;
            end else begin
                m_ack = 1'b0;
                wcnt++;
            end
        end else begin
            m_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Record every completed bus access as {we, addr}.
    always @(negedge clk) begin
        if (reset_n && m_req && m_ack) begin
            bus_log.push_back({m_we, m_addr});
        end
    end

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for i_rdy (want_i=1) or d_rdy (want_i=0).
    task automatic waitFor(input logic want_i, input string tag);
        int n;
        n = 0;
        @(posedge clk);
        while (!(want_i ? i_rdy : d_rdy) && n < 40) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, {63'd0, (want_i ? i_rdy : d_rdy)}, 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        m_rdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        wd_i_req = 1'b0; wd_i_addr = 32'h0;
        wd_d_req = 1'b0; wd_d_we = 1'b0; wd_d_addr = 32'h0; wd_d_wdata = 32'h0;
        repeat (3) @(posedge clk);

        // Reset state
        checkOutput("rst_ctrl", {59'd0, m_req, m_we, i_rdy, d_rdy, bus_err}, 64'd0);
        checkOutput("rst_addr", {32'd0, m_addr}, 64'd0);
        checkOutput("rst_data", {i_data, d_rdata}, 64'd0);
        checkOutput("rst_wd_err", {63'd0, wd_bus_err}, 64'd0);
        reset_n = 1'b1;

        // Zero-wait fetch: m_req one edge later, i_rdy two edges later
        @(posedge clk);
        m_rdata = 32'hDEADBEEF;
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        checkOutput("f1_bus", {30'd0, m_req, m_we, m_addr}, {30'd0, 1'b1, 1'b0, 32'h1000});
        checkOutput("f1_rdy_early", {63'd0, i_rdy}, 64'd0);
        @(posedge clk);
        checkOutput("f1_rdy", {31'd0, i_rdy, i_data}, {31'd0, 1'b1, 32'hDEADBEEF});
        checkOutput("f1_mreq_drop", {63'd0, m_req}, 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        checkOutput("f1_pulse", {31'd0, i_rdy, i_data}, {31'd0, 1'b0, 32'hDEADBEEF});

        // Store and fetch in the same cycle: data first
        m_rdata = 32'h55AA55AA;
        applyStimulus(1'b1, 32'h1001, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        checkOutput("st_bus", {30'd0, m_req, m_we, m_addr}, {30'd0, 1'b1, 1'b1, 32'h20});
        checkOutput("st_wdata", {32'd0, m_wdata}, {32'd0, 32'h12345678});
        waitFor(1'b0, "st_drdy");
        checkOutput("st_irdy_after", {63'd0, i_rdy}, 64'd0);
        checkOutput("st_rdata_kept", {32'd0, d_rdata}, 64'd0);
        d_req = 1'b0;
        waitFor(1'b1, "f2_irdy");
        checkOutput("f2_data", {32'd0, i_data}, {32'd0, 32'h55AA55AA});
        checkOutput("order_len", 64'(bus_log.size()), 64'd3);
        checkOutput("order_0", {31'd0, bus_log[1]}, {31'd0, 1'b1, 32'h20});
        checkOutput("order_1", {31'd0, bus_log[2]}, {31'd0, 1'b0, 32'h1001});
        i_req = 1'b0;

        // Load with 5 wait states
        @(posedge clk);
        wait_states = 5;
        m_rdata = 32'hCAFEF00D;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            checkOutput("ld_hold", {30'd0, m_req, d_rdy, m_addr}, {30'd0, 1'b1, 1'b0, 32'h40});
        end
        @(posedge clk);
        checkOutput("ld_rdy", {31'd0, d_rdy, d_rdata}, {31'd0, 1'b1, 32'hCAFEF00D});
        d_req = 1'b0;
        wait_states = 0;
        @(posedge clk);
        checkOutput("ld_pulse", {63'd0, d_rdy}, 64'd0);

        // Reset while in BUS_D, then late ack, then a fresh fetch
        @(posedge clk);
        slave_en = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        @(posedge clk);
        checkOutput("rs_bus", {31'd0, m_req, m_addr}, {31'd0, 1'b1, 32'h80});
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        checkOutput("rs_drop", {61'd0, m_req, d_rdy, bus_err}, 64'd0);
        checkOutput("rs_rdata", {32'd0, d_rdata}, 64'd0);
        reset_n = 1'b1;
        slave_en = 1'b1;
        force_ack = 1'b1;
        m_rdata = 32'h99999999;
        @(posedge clk);
        checkOutput("rs_late_ack", {60'd0, m_req, d_rdy, i_rdy, bus_err}, 64'd0);
        force_ack = 1'b0;
        m_rdata = 32'h0BADCAFE;
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0);
        waitFor(1'b1, "rs_fetch_rdy");
        checkOutput("rs_fetch_data", {32'd0, i_data}, {32'd0, 32'h0BADCAFE});
        i_req = 1'b0;

        // Repeated fetch of the same address, then store + refetch
        @(posedge clk);
        m_rdata = 32'h11111111;
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
        waitFor(1'b1, "c1_rdy");
        checkOutput("c1_data", {32'd0, i_data}, {32'd0, 32'h11111111});
        i_req = 1'b0;
        n0 = bus_log.size();
        @(posedge clk);
        m_rdata = 32'h22222222;
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
        waitFor(1'b1, "c2_rdy");
`ifdef TENYR_ARB_IFETCH_CACHE_EN
        checkOutput("c2_data", {32'd0, i_data}, {32'd0, 32'h11111111});
        checkOutput("c2_bus_cnt", 64'(bus_log.size() - n0), 64'd0);
`else
        checkOutput("c2_data", {32'd0, i_data}, {32'd0, 32'h22222222});
        checkOutput("c2_bus_cnt", 64'(bus_log.size() - n0), 64'd1);
`endif
        i_req = 1'b0;
        n0 = bus_log.size();
        @(posedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h77777777);
        waitFor(1'b0, "c3_st_rdy");
        d_req = 1'b0;
        @(posedge clk);
        m_rdata = 32'h33333333;
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
        waitFor(1'b1, "c3_rdy");
        checkOutput("c3_data", {32'd0, i_data}, {32'd0, 32'h33333333});
        checkOutput("c3_bus_cnt", 64'(bus_log.size() - n0), 64'd2);
        checkOutput("c3_last", {31'd0, bus_log[bus_log.size() - 1]}, {31'd0, 1'b0, 32'h1000});
        i_req = 1'b0;

        // Watchdog (TIMEOUT=4, slave never acks)
        @(posedge clk);
        wd_d_req  = 1'b1;
        wd_d_we   = 1'b0;
        wd_d_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            checkOutput("wd_wait", {62'd0, wd_m_req, wd_bus_err}, {62'd0, 2'b10});
        end
        @(posedge clk);
        checkOutput("wd_err", {60'd0, wd_m_req, wd_bus_err, wd_d_rdy, wd_i_rdy}, {60'd0, 4'b0100});
        wd_d_req  = 1'b0;
        wd_i_req  = 1'b1;
        wd_i_addr = 32'h400;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            checkOutput("wd_sticky", {60'd0, wd_m_req, wd_bus_err, wd_d_rdy, wd_i_rdy}, {60'd0, 4'b0100});
        end
        reset_n  = 1'b0;
        wd_i_req = 1'b0;
        repeat (2) @(posedge clk);
        checkOutput("wd_rst", {30'd0, wd_m_req, wd_bus_err, wd_m_addr}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
